imem_upload_ctrl: RTL and testbench
===================================

# imem_upload_ctrl

Program-load controller for the instruction memory. Takes a UART byte stream, packs it into 32-bit words and writes them to sequential instruction-memory word addresses, holding the CPU fetch stage in reset while the load is in progress. On completion it releases the CPU so fetch restarts at PC 0. It sits between the UART receiver and the instruction-memory write port, and drives the mode select that shares that port with the fetch stage.

## Interface
Parameters:
- ADDR_W, 14, instruction-memory word-address width; depth = 2^ADDR_W words
- TIMEOUT_CYC, 1_000_000, maximum idle cycles between bytes during a load

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- upg_start  in  1  one-cycle pulse that begins a load; ignored unless state is IDLE or ERR
- rx_valid  in  1  one-cycle strobe, one byte per strobe; no backpressure
- rx_data  in  8  received byte; valid only when rx_valid=1
- imem_we  out  1  instruction-memory write enable, one cycle per word
- imem_addr  out  ADDR_W  word address for the write
- imem_wdata  out  32  word to write
- upg_mode  out  1  1 = memory port owned by the uploader; 0 = owned by fetch
- cpu_hold  out  1  1 = CPU held in reset
- upg_done  out  1  one-cycle pulse on successful completion
- upg_err  out  1  level; high while in ERR

## Operation
- Frame format: count low byte, count high byte (N = 16-bit word count), then 4·N data bytes, little-endian within each word (first byte goes to [7:0]).
- States and transitions:
  - IDLE: upg_start → HDR0.
  - HDR0: byte → HDR1.
  - HDR1: byte → DATA if 0 < N ≤ 2^ADDR_W.
    - N = 0 → DONE, or CSUM when the checksum feature is compiled in.
    - N > 2^ADDR_W → ERR.
  - DATA: after word N is written → DONE, or CSUM when compiled in.
  - DONE: unconditionally → IDLE after one cycle.
  - ERR: upg_start → HDR0.
- Byte lane counter is 2 bits and is cleared on entering DATA.
  - The 4th byte of a word asserts imem_we on the next cycle, with imem_addr = word index (starting at 0) and imem_wdata = the assembled word.
  - The word index increments after each write.
- Word index is ADDR_W+1 bits wide, so N = 2^ADDR_W completes without the address wrapping.
- upg_mode and cpu_hold are 1 in HDR0, HDR1, DATA, CSUM, DONE and ERR; they are 0 only in IDLE.
- upg_start while in HDR0/HDR1/DATA/CSUM/DONE is ignored.
- rx_valid in IDLE or ERR is ignored.
- Timeout: an idle counter is cleared on every rx_valid and on state entry, and counts in HDR0/HDR1/DATA/CSUM. Reaching TIMEOUT_CYC → ERR.
- ERR holds the CPU until a new successful load or rst. Memory contents written before the error are not rolled back.

## Timing
- Reset values of all outputs: imem_we=0, imem_addr=0, imem_wdata=0, upg_mode=0, cpu_hold=0, upg_done=0, upg_err=0. State = IDLE.
- rst mid-load: abort and return to IDLE next edge; cpu_hold drops on that edge.
- Write latency: imem_we is registered and rises one cycle after the 4th-byte strobe of each word.
- A rx_valid in that same cycle is accepted as byte 0 of the next word.
- upg_done is high for exactly the one cycle spent in DONE.
- cpu_hold and upg_mode fall on the edge leaving DONE, so the last write always completes before fetch regains the port.
- Minimum rx_valid spacing is 1 cycle.

## Configuration
- IMEM_UPG_CHECKSUM_EN defined:
  - After the data (or after the header when N=0), one extra byte is received in CSUM.
  - It must equal the XOR of all data bytes; otherwise → ERR. Match → DONE.
  - Header bytes are excluded from the XOR.
  - The running XOR is cleared on HDR0 entry.
- Macro undefined: the CSUM state, XOR register and check are absent; DATA/HDR1 go straight to DONE.

## Structure
- Shared package imem_upg_pkg holds the state enumeration (IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR) and the default TIMEOUT_CYC constant.
- One natural sub-module: upg_word_packer, the byte-to-word shift register with lane counter and word_valid output. The FSM, timeout counter and address counter stay in the top.

## Test plan
- Reset then idle: rst held 3 cycles → all outputs 0; rx_valid bytes with no upg_start → no imem_we.
- Load N=2, bytes 02 00 | 78 56 34 12 | EF BE AD DE → writes addr0=0x12345678, addr1=0xDEADBEEF; upg_done one cycle later; cpu_hold falls after upg_done.
- Back-to-back strobes every cycle for N=1 → exactly one imem_we, one cycle after the 4th byte; no byte lost.
- Header N=0x4001 with ADDR_W=14 → ERR, upg_err=1, cpu_hold stays 1; subsequent upg_start plus a valid N=1 frame → recovers, upg_err=0.
- Timeout: TIMEOUT_CYC=100, stop after 3 data bytes → ERR on cycle 100 after the last byte; rst mid-DATA → IDLE next edge.
- With IMEM_UPG_CHECKSUM_EN, N=1 frame 01 00 11 22 33 44:
  - checksum byte 44 → DONE;
  - checksum byte 00 → ERR.

Source files
------------

// File: rtl/imem_upg_pkg.sv
// imem_upg_pkg: shared definitions for the instruction-memory upload controller.
//   upg_state_e      - controller states (CSUM is only reachable when
//                      IMEM_UPG_CHECKSUM_EN is defined)
//   UPG_TIMEOUT_CYC  - default inter-byte idle limit during a load
package imem_upg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        CSUM,
        DONE,
        ERR
    } upg_state_e;

    localparam int unsigned UPG_TIMEOUT_CYC = 1_000_000;

endpackage

// File: rtl/upg_word_packer.sv
// upg_word_packer: byte-to-word assembler for the upload path.
//   clk, rst     - clock, synchronous active-high reset
//   clr          - holds the lane counter at 0 (asserted outside DATA)
//   byte_valid   - byte strobe, one byte per strobe
//   byte_data    - byte value; first byte of a word lands in [7:0]
//   word_valid   - registered, high one cycle after the 4th byte of a word
//   word_data    - assembled word, stable while word_valid is high
module upg_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;

    always_comb begin
        lane_d  = lane_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (byte_valid) begin
            // Shift right so the first byte ends up in the low lane.
            word_d  = {byte_data, word_q[31:8]};
            lane_d  = lane_q + 2'd1;
            valid_d = (lane_q == 2'd3);
        end
        if (clr) lane_d = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q  <= 2'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    // A byte arriving in the word_valid cycle only updates word_q at the
    // following edge, so word_data still shows the completed word here.
    assign word_valid = valid_q;
    assign word_data  = word_q;

endmodule

// File: rtl/imem_upload_ctrl.sv
// imem_upload_ctrl: loads a UART byte stream into instruction memory.
// Frame: count lo, count hi (N words), then 4*N little-endian data bytes,
// plus a trailing XOR-of-data byte when IMEM_UPG_CHECKSUM_EN is defined.
//   clk, rst         - clock, synchronous active-high reset
//   upg_start        - pulse; starts a load from IDLE or ERR
//   rx_valid/rx_data - received byte strobe and value
//   imem_we/addr/wdata - instruction-memory write port
//   upg_mode, cpu_hold - port ownership / CPU reset hold (0 only in IDLE)
//   upg_done         - one-cycle pulse on success
//   upg_err          - level, high while in ERR
// Optional feature macro: IMEM_UPG_CHECKSUM_EN
module imem_upload_ctrl
    import imem_upg_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = UPG_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upg_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              upg_mode,
    output logic              cpu_hold,
    output logic              upg_done,
    output logic              upg_err
);

    localparam int          TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int          WI_W  = ADDR_W + 1;
    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

`ifdef IMEM_UPG_CHECKSUM_EN
    localparam upg_state_e POST_DATA = CSUM;
`else
    localparam upg_state_e POST_DATA = DONE;
`endif

    upg_state_e      state_q, state_d;
    logic [7:0]      cnt_lo_q, cnt_lo_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [WI_W-1:0] widx_q, widx_d;
    logic [TO_W-1:0] idle_q, idle_d;
    logic            mode_q, done_q, err_q;
`ifdef IMEM_UPG_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    logic        word_valid;
    logic [31:0] word_data;
    logic [15:0] n_hdr;
    logic        last_word;

    upg_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_q != DATA),
        .byte_valid (rx_valid && (state_q == DATA)),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // Word index is one bit wider than the address so N = 2^ADDR_W
    // terminates without the index wrapping back to 0.
    assign last_word = (32'(widx_q) + 32'd1) == 32'(cnt_q);

    always_comb begin
        state_d  = state_q;
        cnt_lo_d = cnt_lo_q;
        cnt_d    = cnt_q;
        widx_d   = widx_q;
        idle_d   = idle_q;
        n_hdr    = {rx_data, cnt_lo_q};
`ifdef IMEM_UPG_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        if (word_valid) widx_d = widx_q + WI_W'(1);

        case (state_q)
            IDLE: if (upg_start) state_d = HDR0;
            HDR0: if (rx_valid) begin
                cnt_lo_d = rx_data;
                state_d  = HDR1;
            end
            HDR1: if (rx_valid) begin
                cnt_d  = n_hdr;
                widx_d = '0;
                if (n_hdr == 16'd0)            state_d = POST_DATA;
                else if (32'(n_hdr) > DEPTH)   state_d = ERR;
                else                           state_d = DATA;
            end
            DATA: begin
                // Leave on the write of the last word, not its 4th byte, so
                // upg_done trails the final imem_we by one cycle.
                if (word_valid && last_word) begin
`ifdef IMEM_UPG_CHECKSUM_EN
                    // A byte in this cycle is already the checksum byte.
                    if (rx_valid) begin
                        if (rx_data == csum_q) state_d = DONE;
                        else                   state_d = ERR;
                    end else begin
                        state_d = CSUM;
                    end
`else
                    state_d = DONE;
`endif
                end
`ifdef IMEM_UPG_CHECKSUM_EN
                else if (rx_valid) csum_d = csum_q ^ rx_data;
`endif
            end
            CSUM: if (rx_valid) begin
`ifdef IMEM_UPG_CHECKSUM_EN
                if (rx_data == csum_q) state_d = DONE;
                else                   state_d = ERR;
`else
                state_d = ERR;
`endif
            end
            DONE: state_d = IDLE;
            ERR:  if (upg_start) state_d = HDR0;
            default: state_d = IDLE;
        endcase

        // Inter-byte watchdog while a frame is being received.
        if (state_q inside {HDR0, HDR1, DATA, CSUM}) begin
            if (rx_valid)                             idle_d = '0;
            else if (idle_q == TO_W'(TIMEOUT_CYC - 1)) state_d = ERR;
            else                                      idle_d = idle_q + TO_W'(1);
        end else begin
            idle_d = '0;
        end
        if (state_d != state_q) idle_d = '0;

`ifdef IMEM_UPG_CHECKSUM_EN
        if (state_d == HDR0 && state_q != HDR0) csum_d = 8'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_lo_q <= 8'd0;
            cnt_q    <= 16'd0;
            widx_q   <= '0;
            idle_q   <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef IMEM_UPG_CHECKSUM_EN
            csum_q   <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_lo_q <= cnt_lo_d;
            cnt_q    <= cnt_d;
            widx_q   <= widx_d;
            idle_q   <= idle_d;
            // Outputs decoded from the next state so they switch on the
            // same edge as the state register.
            mode_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
            err_q    <= (state_d == ERR);
`ifdef IMEM_UPG_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign imem_we    = word_valid;
    assign imem_addr  = widx_q[ADDR_W-1:0];
    assign imem_wdata = word_data;
    assign upg_mode   = mode_q;
    assign cpu_hold   = mode_q;
    assign upg_done   = done_q;
    assign upg_err    = err_q;

endmodule

// File: tb/tb_imem_upload_ctrl.sv
// tb_imem_upload_ctrl: randomized self-checking bench for imem_upload_ctrl.
// Expected writes come from the frame contents (word i goes to address i);
// a monitor records every write and done pulse for comparison.
module tb_imem_upload_ctrl;

    localparam int ADDR_W = 14;
    localparam int TO     = 100;

    logic              clk = 1'b0;
    logic              rst, upg_start, rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we, upg_mode, cpu_hold, upg_done, upg_err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    always #5 clk = ~clk;

    imem_upload_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .upg_start  (upg_start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .upg_mode   (upg_mode),
        .cpu_hold   (cpu_hold),
        .upg_done   (upg_done),
        .upg_err    (upg_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sole writer of the observation records.
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    int                we_cyc_q[$];
    int                done_cnt = 0;
    int                done_cyc = 0;
    logic              hold_at_done = 1'b0;

    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
            we_cyc_q.push_back(cyc);
        end
        if (upg_done) begin
            done_cnt++;
            done_cyc = cyc;
            hold_at_done = cpu_hold;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int last_byte_cyc = 0;

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        last_byte_cyc = cyc;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic start();
        upg_start = 1'b1;
        tick();
        upg_start = 1'b0;
    endtask

    task automatic gap(input int mx);
        if (mx > 0) repeat ($urandom_range(mx, 0)) tick();
    endtask

    logic [31:0] fw[$];

    // Sends fw[] as one frame and checks the resulting writes.
    task automatic run_frame(input int mx, input bit poke);
        int          wb, db, n, lb;
        logic [7:0]  x, b;
        logic [15:0] nn;
        n  = fw.size();
        nn = 16'(n);
        wb = wd_q.size();
        db = done_cnt;
        x  = 8'd0;
        lb = 0;
        start(); gap(mx);
        send(nn[7:0]);  gap(mx);
        send(nn[15:8]); gap(mx);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = fw[i][8*k +: 8];
                x = x ^ b;
                if (poke && k == 1) upg_start = 1'b1;
                send(b);
                upg_start = 1'b0;
                lb = last_byte_cyc;
                gap(mx);
            end
        end
`ifdef IMEM_UPG_CHECKSUM_EN
        send(x);
`endif
        for (int t = 0; t < 10 && done_cnt == db; t++) tick();
        tick(); tick();
        chk("done_pulses", 64'(done_cnt - db), 64'd1);
        chk("num_writes", 64'(wd_q.size() - wb), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (wb + i < wd_q.size()) begin
                chk("wr_addr", 64'(wa_q[wb + i]), 64'(i));
                chk("wr_data", 64'(wd_q[wb + i]), 64'(fw[i]));
            end
        end
        if (n > 0 && wd_q.size() > wb) begin
            chk("we_latency", 64'(we_cyc_q[$]), 64'(lb + 1));
`ifndef IMEM_UPG_CHECKSUM_EN
            chk("done_after_we", 64'(done_cyc), 64'(we_cyc_q[$] + 1));
`endif
        end
        chk("hold_at_done", 64'(hold_at_done), 64'd1);
        chk("hold_after", 64'(cpu_hold), 64'd0);
        chk("mode_after", 64'(upg_mode), 64'd0);
        chk("err_after", 64'(upg_err), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int wb;
        rst = 1'b1; upg_start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        repeat (3) tick();
        chk("rst_we",    64'(imem_we),    64'd0);
        chk("rst_addr",  64'(imem_addr),  64'd0);
        chk("rst_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_mode",  64'(upg_mode),   64'd0);
        chk("rst_hold",  64'(cpu_hold),   64'd0);
        chk("rst_done",  64'(upg_done),   64'd0);
        chk("rst_err",   64'(upg_err),    64'd0);
        rst = 1'b0;
        tick();

        // Bytes without upg_start are ignored.
        wb = wd_q.size();
        repeat (6) send(8'($urandom));
        tick();
        chk("idle_no_we", 64'(wd_q.size() - wb), 64'd0);
        chk("idle_hold", 64'(cpu_hold), 64'd0);

        // Known two-word frame.
        fw.delete(); fw.push_back(32'h12345678); fw.push_back(32'hDEADBEEF);
        run_frame(2, 1'b0);

        // Back-to-back strobes, one word.
        fw.delete(); fw.push_back($urandom);
        run_frame(0, 1'b0);

        // Header-only frame.
        fw.delete();
        run_frame(1, 1'b0);

        // Random frames, some with stray upg_start mid-load.
        for (int r = 0; r < 8; r++) begin
            fw.delete();
            repeat ($urandom_range(6, 1)) fw.push_back($urandom);
            run_frame(r % 4, r[0]);
        end

        // Oversized count goes to ERR and keeps the CPU held.
        start(); send(8'h01); send(8'h40); tick();
        chk("ovf_err",  64'(upg_err),  64'd1);
        chk("ovf_hold", 64'(cpu_hold), 64'd1);
        wb = wd_q.size();
        repeat (4) send(8'($urandom));
        tick();
        chk("err_ignores_rx", 64'(wd_q.size() - wb), 64'd0);
        chk("err_stays", 64'(upg_err), 64'd1);
        fw.delete(); fw.push_back($urandom);
        run_frame(1, 1'b0);

        // Timeout after 3 data bytes.
        start(); send(8'h01); send(8'h00);
        send(8'hA1); send(8'hB2); send(8'hC3);
        repeat (TO - 1) tick();
        chk("to_early", 64'(upg_err), 64'd0);
        tick();
        chk("to_err",  64'(upg_err),  64'd1);
        chk("to_hold", 64'(cpu_hold), 64'd1);

        // Reset mid-DATA drops the hold on the next edge.
        start(); send(8'h02); send(8'h00); send(8'h11); send(8'h22);
        rst = 1'b1;
        tick();
        chk("rst_mid_hold", 64'(cpu_hold), 64'd0);
        chk("rst_mid_err",  64'(upg_err),  64'd0);
        rst = 1'b0;
        wb = wd_q.size();
        repeat (4) send(8'($urandom));
        tick();
        chk("rst_mid_no_we", 64'(wd_q.size() - wb), 64'd0);

`ifdef IMEM_UPG_CHECKSUM_EN
        // Frame 01 00 11 22 33 44 with matching checksum 44.
        fw.delete(); fw.push_back(32'h44332211);
        run_frame(0, 1'b0);
        // Same frame with a wrong checksum byte.
        wb = wd_q.size();
        start(); send(8'h01); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h00);
        tick();
        chk("csum_bad_err",  64'(upg_err),  64'd1);
        chk("csum_bad_hold", 64'(cpu_hold), 64'd1);
        chk("csum_bad_wr",   64'(wd_q.size() - wb), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
